// File: rtl/cfg_arb_if.sv
// rtl/cfg_arb_if.sv - requester and config-master signal bundle for cfg_arb
interface cfg_arb_if;
  logic [3:0]  req;
  logic [95:0] cmd_in;
  logic [3:0]  gnt;
  logic [3:0]  rsp_vld;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        snd_frm;
  logic [23:0] cmd_data;
  logic [15:0] resp;
  logic        rsp_rdy;

  modport slave (
    input  req, cmd_in, resp, rsp_rdy,
    output gnt, rsp_vld, rsp_data, rsp_err, busy, snd_frm, cmd_data
  );

  modport master (
    output req, cmd_in, resp, rsp_rdy,
    input  gnt, rsp_vld, rsp_data, rsp_err, busy, snd_frm, cmd_data
  );
endinterface

// File: rtl/cfg_arb.sv
// rtl/cfg_arb.sv - round-robin arbiter serialising four requesters onto one config master
// Optional response watchdog compiled in with CFG_ARB_TIMEOUT_EN.
module cfg_arb #(
  parameter int TO_W = 20
) (
  input  logic      clk,
  input  logic      rst_n,
  cfg_arb_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] WAIT_CLR = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  if (TO_W < 2) begin : g_to_w_check
    $error("cfg_arb: TO_W must be at least 2");
  end

  logic [2:0]  state;
  logic [1:0]  last_winner;
  logic [1:0]  gnt_idx;
  logic [23:0] cmd_q;
  logic [15:0] rsp_data_q;
  logic [1:0]  rr_idx;
  logic [1:0]  cand;
  logic        rr_hit;
  logic [23:0] sel_frame;
  logic [3:0]  gnt_oh;
  logic        waiting;
  logic        to_hit;

  // Search begins one past the last winner so every requester is served before a repeat.
  always_comb begin
    rr_idx = 2'd0;
    rr_hit = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_winner + 2'(k);
      if (!rr_hit && bus.req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    sel_frame = bus.cmd_in[23:0];
    case (rr_idx)
      2'd0: sel_frame = bus.cmd_in[23:0];
      2'd1: sel_frame = bus.cmd_in[47:24];
      2'd2: sel_frame = bus.cmd_in[71:48];
      2'd3: sel_frame = bus.cmd_in[95:72];
      default: sel_frame = bus.cmd_in[23:0];
    endcase
  end

  assign waiting = (state == WAIT_CLR) || (state == WAIT_RSP);

`ifdef CFG_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = &to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == SEND) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q && (state == DONE);
`else
  assign to_hit      = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= 2'd3;
      gnt_idx     <= 2'd0;
      cmd_q       <= 24'd0;
      rsp_data_q  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            gnt_idx <= rr_idx;
            cmd_q   <= sel_frame;
            state   <= SEND;
          end
        end
        SEND: state <= WAIT_CLR;
        WAIT_CLR: begin
          if (to_hit) begin
            rsp_data_q <= 16'hDEAD;
            state      <= DONE;
          end else if (!bus.rsp_rdy) begin
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (to_hit) begin
            rsp_data_q <= 16'hDEAD;
            state      <= DONE;
          end else if (bus.rsp_rdy) begin
            rsp_data_q <= bus.resp;
            state      <= DONE;
          end
        end
        DONE: begin
          last_winner <= gnt_idx;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant and completion decode straight from state so reset clears them without a clock.
  assign gnt_oh       = 4'b0001 << gnt_idx;
  assign bus.busy     = (state != IDLE);
  assign bus.gnt      = bus.busy ? gnt_oh : 4'b0000;
  assign bus.rsp_vld  = (state == DONE) ? gnt_oh : 4'b0000;
  assign bus.snd_frm  = (state == SEND);
  assign bus.cmd_data = cmd_q;
  assign bus.rsp_data = rsp_data_q;
endmodule

// File: tb/tb_cfg_arb.sv
// tb/tb_cfg_arb.sv - scoreboard bench for cfg_arb
module tb_cfg_arb;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cfg_arb_if bif();

  cfg_arb #(.TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int frm_cnt  = 0;

  logic [1:0]  exp_idx[$];
  logic [23:0] exp_frame[$];
  logic [15:0] exp_data[$];
  logic        exp_err[$];

  bit          master_en = 1'b1;
  bit          silent    = 1'b0;
  bit          use_ovr   = 1'b0;
  logic [15:0] ovr_val   = 16'h0000;

  function automatic logic [15:0] resp_of(input logic [23:0] f);
    return f[23:8] ^ {f[7:0], ~f[7:0]};
  endfunction

  task automatic push_txn(input logic [1:0] idx, input logic err);
    logic [23:0] f;
    f = bif.cmd_in[int'(idx)*24 +: 24];
    exp_idx.push_back(idx);
    exp_frame.push_back(f);
    exp_data.push_back(err ? 16'hDEAD : (use_ovr ? ovr_val : resp_of(f)));
    exp_err.push_back(err);
  endtask

  task automatic drop_front();
    void'(exp_idx.pop_front());
    void'(exp_frame.pop_front());
    void'(exp_data.pop_front());
    void'(exp_err.pop_front());
  endtask

  // Config-master model: leaves a stale ready level and garbage data up for two cycles after each frame.
  task automatic master();
    logic [23:0] f;
    bif.resp    = 16'h0000;
    bif.rsp_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!master_en) begin
        bif.rsp_rdy = 1'b0;
      end else if (rst_n && bif.snd_frm === 1'b1) begin
        f        = bif.cmd_data;
        bif.resp = 16'h0BAD;
        repeat (2) @(negedge clk);
        bif.rsp_rdy = 1'b0;
        repeat (2) @(negedge clk);
        if (!silent) begin
          bif.resp    = use_ovr ? ovr_val : resp_of(f);
          bif.rsp_rdy = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [3:0] e_oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bif.snd_frm === 1'b1) begin
          frm_cnt++;
          checks++;
          if (exp_idx.size() == 0) begin
            failures++;
            $display("FAIL send_unexpected cmd_data=%h gnt=%b required no frame", bif.cmd_data, bif.gnt);
          end else begin
            e_oh = 4'b0001 << exp_idx[0];
            if (bif.cmd_data !== exp_frame[0] || bif.gnt !== e_oh) begin
              failures++;
              $display("FAIL send cmd_data=%h gnt=%b required cmd_data=%h gnt=%b",
                       bif.cmd_data, bif.gnt, exp_frame[0], e_oh);
            end
          end
        end
        if (bif.rsp_vld !== 4'b0000) begin
          done_cnt++;
          checks++;
          if (exp_idx.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected rsp_vld=%b rsp_data=%h required no completion", bif.rsp_vld, bif.rsp_data);
          end else begin
            e_oh = 4'b0001 << exp_idx[0];
            if (bif.rsp_vld !== e_oh || bif.gnt !== e_oh || bif.rsp_data !== exp_data[0] ||
                bif.rsp_err !== exp_err[0] || bif.cmd_data !== exp_frame[0]) begin
              failures++;
              $display("FAIL done rsp_vld=%b gnt=%b data=%h err=%b cmd=%h required rsp_vld=%b data=%h err=%b cmd=%h",
                       bif.rsp_vld, bif.gnt, bif.rsp_data, bif.rsp_err, bif.cmd_data,
                       e_oh, exp_data[0], exp_err[0], exp_frame[0]);
            end
            drop_front();
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input logic [3:0] req_after);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    bif.req = req_after;
    checks++;
    if (done_cnt < target) begin
      failures++;
      $display("FAIL wait_done completions=%0d required=%0d", done_cnt, target);
    end
  endtask

  task automatic wait_frm(input int budget);
    int n;
    n = 0;
    while (bif.snd_frm !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (bif.snd_frm !== 1'b1) begin
      failures++;
      $display("FAIL wait_frm snd_frm=%b required 1 within %0d cycles", bif.snd_frm, budget);
    end
  endtask

  task automatic test_reset();
    bif.req    = 4'b0000;
    bif.cmd_in = 96'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.gnt, bif.rsp_vld, bif.rsp_data, bif.rsp_err, bif.snd_frm, bif.busy, bif.cmd_data} !== 51'd0) begin
      failures++;
      $display("FAIL reset_outputs gnt=%b vld=%b data=%h err=%b snd=%b busy=%b cmd=%h required all zero",
               bif.gnt, bif.rsp_vld, bif.rsp_data, bif.rsp_err, bif.snd_frm, bif.busy, bif.cmd_data);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.busy !== 1'b0 || bif.gnt !== 4'b0000 || bif.snd_frm !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req busy=%b gnt=%b snd=%b required 0 0000 0", bif.busy, bif.gnt, bif.snd_frm);
    end
  endtask

  task automatic test_rotate();
    bif.cmd_in = {24'hDEF012, 24'h789ABC, 24'h4D5E6F, 24'hA1B2C3};
    for (int i = 0; i < 8; i++) push_txn(2'(i), 1'b0);
    @(negedge clk);
    bif.req = 4'b1111;
    wait_done(done_cnt + 8, 200, 4'b0000);
  endtask

  task automatic test_basic();
    int f0;
    repeat (2) @(negedge clk);
    bif.cmd_in[23:0] = 24'h123456;
    use_ovr = 1'b1;
    ovr_val = 16'hBEEF;
    push_txn(2'd0, 1'b0);
    f0 = frm_cnt;
    bif.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bif.snd_frm !== 1'b1 || bif.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL send_latency snd_frm=%b gnt=%b required 1 0001", bif.snd_frm, bif.gnt);
    end
    wait_done(done_cnt + 1, 40, 4'b0000);
    use_ovr = 1'b0;
    checks++;
    if (frm_cnt - f0 != 1) begin
      failures++;
      $display("FAIL send_count frames=%0d required 1", frm_cnt - f0);
    end
  endtask

  task automatic test_stale_ready();
    repeat (2) @(negedge clk);
    bif.cmd_in[95:72] = 24'hC0FFEE;
    push_txn(2'd3, 1'b0);
    bif.req = 4'b1000;
    wait_frm(10);
    repeat (2) @(negedge clk);
    checks++;
    if (bif.rsp_data !== 16'hBEEF || bif.rsp_vld !== 4'b0000 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL stale_ready rsp_data=%h vld=%b busy=%b required BEEF 0000 1", bif.rsp_data, bif.rsp_vld, bif.busy);
    end
    wait_done(done_cnt + 1, 40, 4'b0000);
  endtask

  task automatic test_drop();
    repeat (2) @(negedge clk);
    bif.cmd_in[23:0]  = 24'h0F1E2D;
    bif.cmd_in[71:48] = 24'h5A6B7C;
    push_txn(2'd0, 1'b0);
    push_txn(2'd2, 1'b0);
    bif.req = 4'b0101;
    wait_frm(10);
    bif.req = 4'b0100;
    bif.cmd_in[23:0] = 24'hFFFFFF;
    wait_done(done_cnt + 2, 80, 4'b0000);
  endtask

  task automatic test_reset_mid();
    int d0;
    repeat (2) @(negedge clk);
    master_en = 1'b0;
    bif.cmd_in[47:24] = 24'h777111;
    push_txn(2'd1, 1'b0);
    bif.req = 4'b0010;
    wait_frm(10);
    repeat (3) @(negedge clk);
    checks++;
    if (bif.busy !== 1'b1 || bif.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL pre_reset busy=%b gnt=%b required 1 0010", bif.busy, bif.gnt);
    end
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.gnt, bif.rsp_vld, bif.rsp_data, bif.rsp_err, bif.snd_frm, bif.busy, bif.cmd_data} !== 51'd0) begin
      failures++;
      $display("FAIL reset_async gnt=%b vld=%b data=%h err=%b snd=%b busy=%b cmd=%h required all zero",
               bif.gnt, bif.rsp_vld, bif.rsp_data, bif.rsp_err, bif.snd_frm, bif.busy, bif.cmd_data);
    end
    drop_front();
    bif.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      failures++;
      $display("FAIL reset_no_rsp completions=%0d required %0d", done_cnt, d0);
    end
    master_en = 1'b1;
    bif.cmd_in[23:0] = 24'h0A0B0C;
    push_txn(2'd0, 1'b0);
    bif.req = 4'b1011;
    wait_done(done_cnt + 1, 40, 4'b0000);
  endtask

`ifdef CFG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    repeat (2) @(negedge clk);
    silent = 1'b1;
    bif.cmd_in[71:48] = 24'h135790;
    push_txn(2'd2, 1'b1);
    bif.req = 4'b0100;
    wait_frm(10);
    n = 0;
    while (bif.rsp_vld === 4'b0000 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n < 15 || n > 17) begin
      failures++;
      $display("FAIL timeout_latency cycles=%0d required 15..17", n);
    end
    wait_done(done_cnt, 5, 4'b0000);
    silent = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "tb_cfg_arb watchdog");
  end

  initial begin
    bif.req    = 4'b0000;
    bif.cmd_in = 96'd0;
    fork
      master();
      monitor();
    join_none
    test_reset();
    test_rotate();
    test_basic();
    test_stale_ready();
    test_drop();
    test_reset_mid();
`ifdef CFG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (exp_idx.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected entries=%0d required 0", exp_idx.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cfg_arb.md
CFG_ARB -- requirements
Module: cfg_arb

Interface
REQ-001 Parameter: TO_W, default 20, width of the response-timeout counter; used only when CFG_ARB_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester transaction request; the requester holds it high until its rsp_vld bit pulses.
REQ-005 cmd_in  input  96  four 24-bit command frames; requester i drives bits [24i+23:24i].
REQ-006 gnt  output  4  one-hot grant; all zero when no transaction is active.
REQ-007 rsp_vld  output  4  one-cycle pulse on the bit of the served requester when its transaction completes.
REQ-008 rsp_data  output  16  response word; valid in the rsp_vld cycle and held until the next completion.
REQ-009 rsp_err  output  1  high with rsp_vld when the transaction timed out; otherwise low.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 snd_frm  output  1  one-cycle frame-send strobe to the config master.
REQ-012 cmd_data  output  24  registered command frame to the config master.
REQ-013 resp  input  16  response word from the config master.
REQ-014 rsp_rdy  input  1  config-master response-ready level; it stays high after a response until the master clears it during the next frame.

Function
REQ-015 The state machine SHALL have exactly these states: IDLE, SEND, WAIT_CLR, WAIT_RSP, DONE.
REQ-016 IDLE, no req bit set: stay in IDLE; all outputs hold their reset or hold values.
REQ-017 IDLE, any req bit set: select the winner by round-robin.
  - Search starts at (last_winner+1) mod 4 and takes the first set bit.
  - Latch the winner's frame into cmd_data and its index into the grant register.
  - Go to SEND.
REQ-018 SEND lasts one cycle.
  - snd_frm is high for exactly this cycle.
  - gnt is high from this cycle through the DONE cycle inclusive.
  - Next state is WAIT_CLR.
  - Latency: req sampled high at IDLE edge k gives snd_frm and gnt high in cycle k+1.
REQ-019 WAIT_CLR: wait for rsp_rdy==0, then go to WAIT_RSP; this rejects the stale ready level left from the previous frame.
REQ-020 WAIT_RSP: wait for rsp_rdy==1, capture resp into rsp_data, then go to DONE.
REQ-021 DONE lasts one cycle.
  - Pulse rsp_vld for the granted index.
  - Update last_winner to the granted index.
  - Go to IDLE; arbitration can restart on the next edge.
REQ-022 cmd_data SHALL stay stable from SEND through DONE; changes on cmd_in during that window have no effect.
REQ-023 Deasserting the granted req bit mid-transaction SHALL NOT abort the transaction; it still completes and pulses rsp_vld.
REQ-024 New or changed req bits during a transaction SHALL be ignored until the next IDLE evaluation.
REQ-025 Only one transaction SHALL be outstanding at a time; snd_frm SHALL never assert outside SEND.
REQ-026 gnt SHALL be one-hot or zero; rsp_vld SHALL be one-hot or zero and SHALL equal gnt in the DONE cycle.
REQ-027 If all four requesters stay asserted, grants SHALL rotate 0,1,2,3,0... with no requester served twice before the others are served once.

Reset
REQ-028 With rst_n low, the following SHALL hold immediately:
  - state = IDLE;
  - gnt, rsp_vld, rsp_data, rsp_err, snd_frm, busy and cmd_data = 0;
  - last_winner = 3, so requester 0 has first priority.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction with no rsp_vld pulse; after release the block restarts from IDLE.

Configuration
REQ-030 The macro CFG_ARB_TIMEOUT_EN SHALL compile the response watchdog in or out.
REQ-031 With CFG_ARB_TIMEOUT_EN defined:
  - A TO_W-bit counter clears in SEND and increments each cycle in WAIT_CLR and WAIT_RSP.
  - When the counter reaches all-ones, go to DONE with rsp_err=1 and rsp_data=16'hDEAD.
  - last_winner advances as normal.
REQ-032 Without CFG_ARB_TIMEOUT_EN:
  - No counter logic exists.
  - WAIT_CLR and WAIT_RSP wait indefinitely.
  - rsp_err is tied to 0.

Verification
REQ-033 After reset, set req=4'b0001 with frame 24'h12_34_56 and return resp=16'hBEEF.
  - snd_frm pulses once with cmd_data=24'h123456.
  - rsp_vld=4'b0001, rsp_data=16'hBEEF, rsp_err=0.
REQ-034 Hold req=4'b1111 for 8 transactions: gnt sequence is 0,1,2,3,0,1,2,3.
REQ-035 Set req=4'b0101, then drop bit 0 after snd_frm: requester 0 still completes, then requester 2 is granted.
REQ-036 Hold rsp_rdy high across snd_frm: no capture until rsp_rdy falls and rises again; rsp_data is the new response value.
REQ-037 With CFG_ARB_TIMEOUT_EN defined and TO_W=4, never raise rsp_rdy: rsp_vld pulses with rsp_err=1 and rsp_data=16'hDEAD 15 cycles after the counter starts.
REQ-038 Pulse rst_n low while in WAIT_RSP: all outputs are zero immediately, no rsp_vld pulse, and the next grant goes to requester 0.
